blockmix_salsa_ctrl: RTL and testbench

//  Initiator for the salsa_20_8 core: runs scrypt BlockMix_salsa20/8 over one 128*R-byte block.

---
 rtl/scrypt_pkg.sv | 21 ++
 rtl/blockmix_salsa_ctrl_if.sv | 46 ++++
 rtl/blockmix_yreg.sv | 43 ++++
 rtl/blockmix_salsa_ctrl.sv | 135 +++++++++++++
 tb/tb_blockmix_salsa_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scrypt_pkg.sv
// Shared scrypt definitions: salsa word geometry, BlockMix FSM states and the
// mapping from a salsa call index to its slot in the mixed output block.
package scrypt_pkg;

  localparam int SALSA_W = 512;
  localparam int WORD_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE,
    DONE
  } state_t;

  // Even results fill the upper half of B' in order, odd results the lower half.
  function automatic int yidx_to_out_slot(input int i, input int r);
    return (i % 2 == 0) ? (i / 2) : (r + i / 2);
  endfunction

endpackage

// File: rtl/blockmix_salsa_ctrl_if.sv
// Block stream and salsa-core signals of the BlockMix controller.
// slave is the controller side, master the ROMix/core environment side.
interface blockmix_salsa_ctrl_if
  import scrypt_pkg::*;
#(
  parameter int R = 1
);

  logic                  in_valid;
  logic                  in_ready;
  logic [1024*R-1:0]     block_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [1024*R-1:0]     block_out;
  logic                  salsa_init;
  logic [SALSA_W-1:0]    salsa_x;
  logic [SALSA_W-1:0]    salsa_out;
  logic                  salsa_valid;

  modport slave (
    input  in_valid,
    input  block_in,
    input  out_ready,
    input  salsa_out,
    input  salsa_valid,
    output in_ready,
    output out_valid,
    output block_out,
    output salsa_init,
    output salsa_x
  );

  modport master (
    output in_valid,
    output block_in,
    output out_ready,
    output salsa_out,
    output salsa_valid,
    input  in_ready,
    input  out_valid,
    input  block_out,
    input  salsa_init,
    input  salsa_x
  );

endinterface

// File: rtl/blockmix_yreg.sv
// 2R x 512-bit result register file; slot 0 sits in the MSBs of the flat read port.
module blockmix_yreg
  import scrypt_pkg::*;
#(
  parameter int R = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_en,
  input  logic [$clog2(2*R)-1:0]      wr_slot,
  input  logic [SALSA_W-1:0]          wr_data,
  output wire  [1024*R-1:0]           rd_flat
);

  localparam int NSLOT  = 2 * R;
  localparam int BLK_W  = 1024 * R;
  localparam int SLOT_W = $clog2(NSLOT);

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      logic [SALSA_W-1:0] y_q;
      logic [SALSA_W-1:0] y_d;

      always_comb begin
        y_d = y_q;
        if (wr_en && (wr_slot == SLOT_W'(gi))) begin
          y_d = wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          y_q <= '0;
        end else begin
          y_q <= y_d;
        end
      end

      assign rd_flat[BLK_W-1-SALSA_W*gi -: SALSA_W] = y_q;
    end
  endgenerate

endmodule

// File: rtl/blockmix_salsa_ctrl.sv
// scrypt BlockMix_salsa20/8 initiator: feeds X ^ Bi to an external salsa core
// 2R times, chains the results through X and returns them reordered as B'.
module blockmix_salsa_ctrl
  import scrypt_pkg::*;
#(
  parameter int R = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  blockmix_salsa_ctrl_if.slave  bus
);

  localparam int NSUB   = 2 * R;
  localparam int BLK_W  = 1024 * R;
  localparam int SLOT_W = $clog2(NSUB);
  localparam int I_W    = $clog2(NSUB) + 1;
  localparam logic [I_W-1:0] I_LAST = I_W'(NSUB - 1);

  state_t               state_q, state_d;
  logic [I_W-1:0]       i_q, i_d;
  logic [BLK_W-1:0]     b_q, b_d;
  logic [SALSA_W-1:0]   x_q, x_d;
  logic [SALSA_W-1:0]   sx_q, sx_d;
  logic                 init_q, init_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic                 y_we;
  logic [SLOT_W-1:0]    y_slot;
  wire  [BLK_W-1:0]     y_flat;
  wire  [SALSA_W-1:0]   b_sub [NSUB];
  logic [SALSA_W-1:0]   b_cur;

  generate
    for (genvar gi = 0; gi < NSUB; gi++) begin : g_bsub
      assign b_sub[gi] = b_q[BLK_W-1-SALSA_W*gi -: SALSA_W];
    end
  endgenerate

  always_comb begin
    b_cur  = b_sub[i_q[SLOT_W-1:0]];
    y_slot = SLOT_W'(yidx_to_out_slot(int'(i_q), R));
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    b_d     = b_q;
    x_d     = x_q;
    sx_d    = sx_q;
    y_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          b_d     = bus.block_in;
          // B(2R-1) is the last sub-block, i.e. the LSBs of the input
          x_d     = bus.block_in[SALSA_W-1:0];
          i_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sx_d    = x_q ^ b_cur;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.salsa_valid) begin
          x_d     = bus.salsa_out;
          y_we    = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (i_q == I_LAST) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + I_W'(1);
          state_d = ISSUE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered copies of the next-state decode
    init_d      = (state_d == WAIT);
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      b_q         <= '0;
      x_q         <= '0;
      sx_q        <= '0;
      init_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      b_q         <= b_d;
      x_q         <= x_d;
      sx_q        <= sx_d;
      init_q      <= init_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  blockmix_yreg #(
    .R (R)
  ) u_yreg (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (y_we),
    .wr_slot (y_slot),
    .wr_data (bus.salsa_out),
    .rd_flat (y_flat)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.salsa_init = init_q;
  assign bus.salsa_x    = sx_q;
  assign bus.block_out  = y_flat;

endmodule

// File: tb/tb_blockmix_salsa_ctrl.sv
// Scoreboard bench for blockmix_salsa_ctrl: R=1 and R=2 instances, each with a
// salsa core model of configurable latency (real Salsa20/8 or identity).
module tb_blockmix_salsa_ctrl;
  import scrypt_pkg::*;

  typedef logic [15:0][31:0] w16_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  blockmix_salsa_ctrl_if #(.R(1)) bus1 ();
  blockmix_salsa_ctrl_if #(.R(2)) bus2 ();

  blockmix_salsa_ctrl #(.R(1)) u_dut1 (.clk(clk), .reset_n(rst_n), .bus(bus1.slave));
  blockmix_salsa_ctrl #(.R(2)) u_dut2 (.clk(clk), .reset_n(rst_n), .bus(bus2.slave));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1023:0] exp1 [$];
  logic [2047:0] exp2 [$];

  // ---------------- reference functions ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic w16_t qr(input w16_t x, input int a, input int b, input int c, input int d);
    x[b] = x[b] ^ rotl(x[a] + x[d], 7);
    x[c] = x[c] ^ rotl(x[b] + x[a], 9);
    x[d] = x[d] ^ rotl(x[c] + x[b], 13);
    x[a] = x[a] ^ rotl(x[d] + x[c], 18);
    return x;
  endfunction

  function automatic logic [511:0] salsa8(input logic [511:0] in);
    w16_t s, x;
    logic [511:0] o;
    for (int k = 0; k < 16; k++) s[k] = in[511-32*k -: 32];
    x = s;
    for (int r = 0; r < 4; r++) begin
      x = qr(x, 0, 4, 8, 12);
      x = qr(x, 5, 9, 13, 1);
      x = qr(x, 10, 14, 2, 6);
      x = qr(x, 15, 3, 7, 11);
      x = qr(x, 0, 1, 2, 3);
      x = qr(x, 5, 6, 7, 4);
      x = qr(x, 10, 11, 8, 9);
      x = qr(x, 15, 12, 13, 14);
    end
    for (int k = 0; k < 16; k++) o[511-32*k -: 32] = x[k] + s[k];
    return o;
  endfunction

  // BlockMix over a right-aligned 1024*r-bit block; mode 1 = real salsa, 0 = identity
  function automatic logic [2047:0] ref_blockmix(input logic [2047:0] b, input int r, input int mode);
    logic [511:0]  xv;
    logic [2047:0] o;
    int slot;
    o  = '0;
    xv = b[511:0];
    for (int i = 0; i < 2*r; i++) begin
      xv = xv ^ b[1024*r-1-512*i -: 512];
      if (mode == 1) xv = salsa8(xv);
      slot = (i % 2 == 0) ? i / 2 : r + i / 2;
      o[1024*r-1-512*slot -: 512] = xv;
    end
    return o;
  endfunction

  function automatic logic [1023:0] ref1(input logic [1023:0] b, input int mode);
    logic [2047:0] t;
    t = ref_blockmix({1024'b0, b}, 1, mode);
    return t[1023:0];
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic chk_blk(input string name, input logic [2047:0] act, input logic [2047:0] req, input int nslots);
    int bad;
    bad = -1;
    checks++;
    for (int s = 0; s < nslots; s++) begin
      if (bad < 0 && act[512*(nslots-1-s) +: 512] !== req[512*(nslots-1-s) +: 512]) bad = s;
    end
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s slot %0d: got %h required %h", name, bad,
               act[512*(nslots-1-bad) +: 512], req[512*(nslots-1-bad) +: 512]);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required event within cycle budget", name);
  endtask

  // ---------------- salsa core models ----------------
  int   lat1 = 0, mode1 = 0, cnt1 = 0;
  logic done1 = 1'b0, fv1 = 1'b0;
  int   cnt2 = 0;
  logic done2 = 1'b0;

  always @(posedge clk) begin
    if (!bus1.salsa_init) begin
      cnt1  <= 0;
      done1 <= 1'b0;
    end else if (bus1.salsa_valid) begin
      done1 <= 1'b1;
    end else begin
      cnt1 <= cnt1 + 1;
    end
  end
  assign bus1.salsa_valid = (bus1.salsa_init && !done1 && (cnt1 == lat1)) || fv1;
  assign bus1.salsa_out   = (mode1 == 1) ? salsa8(bus1.salsa_x) : bus1.salsa_x;

  // R=2 core: identity, valid in the same cycle as init
  always @(posedge clk) begin
    if (!bus2.salsa_init) begin
      cnt2  <= 0;
      done2 <= 1'b0;
    end else if (bus2.salsa_valid) begin
      done2 <= 1'b1;
    end else begin
      cnt2 <= cnt2 + 1;
    end
  end
  assign bus2.salsa_valid = bus2.salsa_init && !done2 && (cnt2 == 0);
  assign bus2.salsa_out   = bus2.salsa_x;

  // ---------------- monitors ----------------
  int   rises1 = 0, acc1 = 0, latm1 = -1, acc2 = 0, latm2 = -1;
  logic pinit1 = 1'b0, pov1 = 1'b0, pov2 = 1'b0;

  always @(negedge clk) begin
    logic [1023:0] e;
    if (rst_n) begin
      if (bus1.salsa_init && !pinit1) rises1++;
      pinit1 = bus1.salsa_init;
      if (bus1.in_valid && bus1.in_ready) acc1 = cyc + 1;
      if (bus1.out_valid && !pov1) latm1 = cyc - acc1;
      pov1 = bus1.out_valid;
      if (bus1.out_valid && bus1.out_ready) begin
        if (exp1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out1_unexpected: got out_valid with empty queue required no output");
        end else begin
          e = exp1.pop_front();
          chk_blk("out1_data", {1024'b0, bus1.block_out}, {1024'b0, e}, 2);
        end
      end
    end else begin
      pinit1 = 1'b0;
      pov1   = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [2047:0] e;
    if (rst_n) begin
      if (bus2.in_valid && bus2.in_ready) acc2 = cyc + 1;
      if (bus2.out_valid && !pov2) latm2 = cyc - acc2;
      pov2 = bus2.out_valid;
      if (bus2.out_valid && bus2.out_ready) begin
        if (exp2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out2_unexpected: got out_valid with empty queue required no output");
        end else begin
          e = exp2.pop_front();
          chk_blk("out2_data", bus2.block_out, e, 4);
        end
      end
    end else begin
      pov2 = 1'b0;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send1(input logic [1023:0] b, input logic [1023:0] e);
    int n;
    n = 0;
    while (!bus1.in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!bus1.in_ready) begin
      timeout("send1_ready");
    end else begin
      exp1.push_back(e);
      bus1.in_valid = 1'b1;
      bus1.block_in = b;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
    end
  endtask

  task automatic drain1(input string name);
    int n;
    n = 0;
    while (exp1.size() != 0 && n < 400) begin @(posedge clk); #1; n++; end
    if (exp1.size() != 0) timeout(name);
    @(posedge clk); #1;
  endtask

  task automatic send2(input logic [2047:0] b);
    int n;
    n = 0;
    while (!bus2.in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!bus2.in_ready) begin
      timeout("send2_ready");
    end else begin
      exp2.push_back(ref_blockmix(b, 2, 0));
      bus2.in_valid = 1'b1;
      bus2.block_in = b;
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish within budget");
    $fatal(1, "global timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [1023:0] blk, snap, hand;
    int base, n;

    rst_n = 1'b0;
    bus1.in_valid = 1'b0; bus1.block_in = '0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.block_in = '0; bus2.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus1.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus1.out_valid), 64'd0);
    chk("rst_salsa_init", 64'(bus1.salsa_init), 64'd0);
    chk("rst_salsa_x", 64'(bus1.salsa_x != '0), 64'd0);
    chk_blk("rst_block_out", {1024'b0, bus1.block_out}, '0, 2);
    chk("rst2_in_ready", 64'(bus2.in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: zero block through real salsa
    mode1 = 1; lat1 = 3; base = rises1;
    send1('0, '0);
    drain1("t1_done");
    chk("t1_init_rises", 64'(rises1 - base), 64'd2);
    chk("t1_latency", 64'(latm1), 64'(2 * (3 + 3)));

    // real salsa on a non-trivial block
    blk = {{16{32'h01234567}}, {16{32'h89abcdef}}};
    send1(blk, ref1(blk, 1));
    drain1("t1b_done");

    // 2: identity model, latency 4, hand-computed result
    mode1 = 0; lat1 = 4;
    hand = {{16{32'h6d8612e6}}, {16{32'hae042d63}}};
    send1({{16{32'hae042d63}}, {16{32'hc3823f85}}}, hand);
    drain1("t2_done");
    chk("t2_latency", 64'(latm1), 64'(2 * (4 + 3)));

    // 3: back-pressure for 10 cycles
    lat1 = 1;
    bus1.out_ready = 1'b0;
    blk = {{8{64'h0123456789abcdef}}, {8{64'hfedcba9876543210}}};
    send1(blk, ref1(blk, 0));
    n = 0;
    while (!bus1.out_valid && n < 300) begin @(posedge clk); #1; n++; end
    if (!bus1.out_valid) timeout("t3_out_valid");
    snap = bus1.block_out;
    repeat (10) begin
      @(posedge clk); #1;
      chk("t3_hold_valid", 64'(bus1.out_valid), 64'd1);
      chk("t3_hold_in_ready", 64'(bus1.in_ready), 64'd0);
      chk_blk("t3_hold_data", {1024'b0, bus1.block_out}, {1024'b0, snap}, 2);
    end
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_release_valid", 64'(bus1.out_valid), 64'd0);
    chk("t3_release_in_ready", 64'(bus1.in_ready), 64'd1);
    chk("t3_queue_empty", 64'(exp1.size()), 64'd0);

    // 4: reset during the second WAIT
    lat1 = 4; base = rises1;
    blk = {{16{32'h5a5a0f0f}}, {16{32'h3c3c9696}}};
    send1(blk, ref1(blk, 0));
    n = 0;
    while (rises1 < base + 2 && n < 300) begin @(posedge clk); #1; n++; end
    if (rises1 < base + 2) timeout("t4_second_wait");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(exp1.pop_back());
    chk("t4_salsa_init", 64'(bus1.salsa_init), 64'd0);
    chk("t4_out_valid", 64'(bus1.out_valid), 64'd0);
    chk("t4_in_ready", 64'(bus1.in_ready), 64'd1);
    chk_blk("t4_block_out", {1024'b0, bus1.block_out}, '0, 2);
    blk = {{16{32'h00ff00ff}}, {16{32'h12345678}}};
    send1(blk, ref1(blk, 0));
    drain1("t4_after_done");

    // 5: in_valid while busy is dropped; stray salsa_valid in IDLE is inert
    lat1 = 2;
    blk = {{16{32'hdeadbeef}}, {16{32'h0badf00d}}};
    send1(blk, ref1(blk, 0));
    repeat (3) @(posedge clk);
    #1;
    bus1.in_valid = 1'b1;
    bus1.block_in = {{16{32'h11111111}}, {16{32'h22222222}}};
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    drain1("t5_done");
    repeat (20) @(posedge clk);
    #1;
    fv1 = 1'b1;
    @(posedge clk); #1;
    fv1 = 1'b0;
    @(posedge clk); #1;
    chk("t5_idle_in_ready", 64'(bus1.in_ready), 64'd1);
    chk("t5_idle_init", 64'(bus1.salsa_init), 64'd0);
    chk("t5_idle_out_valid", 64'(bus1.out_valid), 64'd0);
    blk = {{16{32'h76543210}}, {16{32'h9abcdef0}}};
    send1(blk, ref1(blk, 0));
    drain1("t5b_done");

    // 6: R=2, identity model, latency 0
    send2({{16{32'hae042d63}}, {16{32'hc3823f85}}, {16{32'h0f1e2d3c}}, {16{32'h80000001}}});
    n = 0;
    while (exp2.size() != 0 && n < 400) begin @(posedge clk); #1; n++; end
    if (exp2.size() != 0) timeout("t6_done");
    chk("t6_latency", 64'(latm2), 64'(4 * (0 + 3)));
    send2({{8{64'h0011223344556677}}, {8{64'h8899aabbccddeeff}},
           {8{64'hffeeddccbbaa9988}}, {8{64'h7766554433221100}}});
    n = 0;
    while (exp2.size() != 0 && n < 400) begin @(posedge clk); #1; n++; end
    if (exp2.size() != 0) timeout("t6b_done");

    repeat (5) @(posedge clk);
    #1;
    chk("end_queue1", 64'(exp1.size()), 64'd0);
    chk("end_queue2", 64'(exp2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
